// File: rtl/ahb_pkg.sv
// AHB protocol codes and master FSM encoding shared by the AHB master and slave blocks.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_BURST,
        S_LAST,
        S_ERR
    } state_t;

    // Beat count for a burst code; undefined-length INCR takes cmd_len, 0 meaning 1.
    function automatic logic [4:0] burst_beats(input logic [2:0] burst, input logic [4:0] len);
        logic [4:0] n;
        case (burst)
            HBURST_SINGLE:                n = 5'd1;
            HBURST_WRAP4, HBURST_INCR4:   n = 5'd4;
            HBURST_WRAP8, HBURST_INCR8:   n = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: n = 5'd16;
            default:                      n = (len == 5'd0) ? 5'd1 : len;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ahb_burst_addr_gen.sv
// Next-beat address for AHB bursts: wrap within the 4n-byte window, or
// increment by one word and flag landing on a new 1 KB page.
module ahb_burst_addr_gen
    import ahb_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic [AW-1:0] addr,
    input  logic [2:0]    burst,
    output logic [AW-1:0] next_addr,
    output logic          page_cross
);

    logic [AW-1:0] inc;
    logic [AW-1:0] mask;

    always_comb begin
        inc = addr + AW'(4);
        case (burst)
            HBURST_WRAP4:  mask = AW'(15);
            HBURST_WRAP8:  mask = AW'(31);
            HBURST_WRAP16: mask = AW'(63);
            default:       mask = '0;
        endcase
        next_addr  = (mask == '0) ? inc : ((addr & ~mask) | (inc & mask));
        page_cross = (mask == '0) && (inc[9:0] == 10'd0);
    end

endmodule

// File: rtl/ahb_burst_master.sv
// AHB-Lite burst master: turns one command into a pipelined word burst,
// splitting INCR bursts at 1 KB pages and aborting on any non-OKAY response.
module ahb_burst_master
    import ahb_pkg::*;
#(
    parameter int AW     = 32,
    parameter int MAXLEN = 16
) (
    input  logic          hclk,
    input  logic          hreset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [2:0]    cmd_burst,
    input  logic [4:0]    cmd_len,
    input  logic [31:0]   wdata,
    output logic          wdata_req,
    output logic          wdata_ack,
    output logic [31:0]   rdata,
    output logic          rdata_valid,
    output logic          done,
    output logic          err,
    output logic [1:0]    htrans,
    output logic [AW-1:0] haddr,
    output logic          hwrite,
    output logic [2:0]    hsize,
    output logic [2:0]    hburst,
    output logic [31:0]   hwdata,
    input  logic          hready,
    input  logic [1:0]    hresp,
    input  logic [31:0]   hrdata
);

    state_t        state, state_nx;
    logic [AW-1:0] addr_q, addr_nx, addr_inc;
    logic [2:0]    burst_q, burst_nx;
    logic          write_q, write_nx;
    logic [4:0]    left_q, left_nx, cmd_beats;
    logic          dphase, dphase_nx;
    logic          page_cross, addr_act, resp_ok, done_c, err_c;

    ahb_burst_addr_gen #(.AW(AW)) u_addr_gen (
        .addr       (addr_q),
        .burst      (burst_q),
        .next_addr  (addr_inc),
        .page_cross (page_cross)
    );

    assign cmd_beats = (cmd_burst == HBURST_INCR && cmd_len > 5'(MAXLEN)) ? 5'(MAXLEN)
                                                                           : burst_beats(cmd_burst, cmd_len);
    assign addr_act  = (state == S_ADDR) || (state == S_BURST);
    assign resp_ok   = (hresp == HRESP_OKAY);

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            burst_q <= HBURST_SINGLE;
            write_q <= 1'b0;
            left_q  <= 5'd0;
            dphase  <= 1'b0;
        end else begin
            state   <= state_nx;
            addr_q  <= addr_nx;
            burst_q <= burst_nx;
            write_q <= write_nx;
            left_q  <= left_nx;
            dphase  <= dphase_nx;
        end
    end

    // left_q counts address phases still to be issued, including the one on the bus.
    always_comb begin
        state_nx  = state;
        addr_nx   = addr_q;
        burst_nx  = burst_q;
        write_nx  = write_q;
        left_nx   = left_q;
        dphase_nx = dphase;
        done_c    = 1'b0;
        err_c     = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    write_nx = cmd_write;
                    if (cmd_addr[1:0] != 2'b00) begin
                        state_nx = S_ERR;
                    end else begin
                        addr_nx  = cmd_addr;
                        burst_nx = cmd_burst;
                        left_nx  = cmd_beats;
                        state_nx = S_ADDR;
                    end
                end
            end
            S_ADDR, S_BURST, S_LAST: begin
                if (dphase && !resp_ok) begin
                    if (hready) begin
                        done_c    = 1'b1;
                        err_c     = 1'b1;
                        dphase_nx = 1'b0;
                        state_nx  = S_IDLE;
                    end else begin
                        state_nx = S_ERR;
                    end
                end else if (hready) begin
                    dphase_nx = addr_act;
                    if (state == S_LAST) begin
                        done_c   = 1'b1;
                        state_nx = S_IDLE;
                    end else if (left_q == 5'd1) begin
                        state_nx = S_LAST;
                    end else begin
                        addr_nx = addr_inc;
                        left_nx = left_q - 5'd1;
                        // A new 1 KB page restarts as an undefined-length INCR.
                        if (page_cross) begin
                            burst_nx = HBURST_INCR;
                            state_nx = S_ADDR;
                        end else begin
                            state_nx = S_BURST;
                        end
                    end
                end
            end
            S_ERR: begin
                // Misaligned commands arrive here with no data phase and finish at once.
                if (!dphase || hready) begin
                    done_c    = 1'b1;
                    err_c     = 1'b1;
                    dphase_nx = 1'b0;
                    state_nx  = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign cmd_ready   = !hreset && (state == S_IDLE);
    assign htrans      = hreset             ? HTRANS_IDLE   :
                         (state == S_ADDR)  ? HTRANS_NONSEQ :
                         (state == S_BURST) ? HTRANS_SEQ    : HTRANS_IDLE;
    assign haddr       = hreset ? '0 : addr_q;
    assign hwrite      = !hreset && write_q;
    assign hburst      = hreset ? HBURST_SINGLE : burst_q;
    assign hsize       = HSIZE_WORD;
    assign hwdata      = wdata;
    assign rdata       = hrdata;
    assign wdata_req   = !hreset && dphase && write_q;
    assign wdata_ack   = wdata_req && hready && resp_ok;
    assign rdata_valid = !hreset && dphase && !write_q && hready && resp_ok;
    assign done        = !hreset && done_c;
    assign err         = !hreset && err_c;

endmodule

// File: tb/tb_ahb_burst_master.sv
// Scoreboard bench for ahb_burst_master: a responding slave model plus queues of
// expected address phases, read data and completion status per command.
module tb_ahb_burst_master;
    import ahb_pkg::*;

    logic        hclk = 1'b0;
    logic        hreset, cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_burst;
    logic [4:0]  cmd_len;
    logic [31:0] wdata, rdata, hwdata, hrdata, haddr;
    logic        wdata_req, wdata_ack, rdata_valid, done, err, hwrite, hready;
    logic [1:0]  htrans, hresp;
    logic [2:0]  hsize, hburst;

    always #5 hclk = ~hclk;

    ahb_burst_master #(.AW(32), .MAXLEN(16)) dut (
        .hclk(hclk), .hreset(hreset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_burst(cmd_burst), .cmd_len(cmd_len),
        .wdata(wdata), .wdata_req(wdata_req), .wdata_ack(wdata_ack), .rdata(rdata),
        .rdata_valid(rdata_valid), .done(done), .err(err), .htrans(htrans), .haddr(haddr),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hready(hready),
        .hresp(hresp), .hrdata(hrdata)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic [2:0]  burst;
    } aph_t;

    aph_t        exp_a[$];
    logic [31:0] exp_r[$];
    logic        exp_e[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int nbeats(input logic [2:0] b, input logic [4:0] l);
        case (b)
            HBURST_SINGLE:                return 1;
            HBURST_WRAP4, HBURST_INCR4:   return 4;
            HBURST_WRAP8, HBURST_INCR8:   return 8;
            HBURST_WRAP16, HBURST_INCR16: return 16;
            default:                      return (l == 5'd0) ? 1 : int'(l);
        endcase
    endfunction

    // eb: 1-based data beat that receives an error response (0 = none).
    function automatic void push_exp(input logic wr, input logic [31:0] a, input logic [2:0] b,
                                     input logic [4:0] l, input int eb);
        int          n, nacc;
        logic [31:0] span, cur;
        logic [2:0]  bc;
        aph_t        ap;
        n    = nbeats(b, l);
        nacc = (eb > 0) ? eb : n;
        bc   = b;
        span = (b == HBURST_WRAP4) ? 32'd16 : (b == HBURST_WRAP8) ? 32'd32 :
               (b == HBURST_WRAP16) ? 32'd64 : 32'd0;
        exp_e.push_back((eb > 0) || (a[1:0] != 2'b00));
        if (a[1:0] != 2'b00) return;
        for (int i = 0; i < nacc; i++) begin
            if (span == 0) cur = a + 32'(4 * i);
            else           cur = (a / span) * span + ((a % span) + 32'(4 * i)) % span;
            ap.addr = cur;
            if (i == 0) ap.trans = HTRANS_NONSEQ;
            else if (span == 0 && (cur % 1024) == 0) begin
                ap.trans = HTRANS_NONSEQ;
                bc       = HBURST_INCR;
            end else ap.trans = HTRANS_SEQ;
            ap.burst = bc;
            exp_a.push_back(ap);
            if (!wr && (eb == 0 || i < eb - 1)) exp_r.push_back(cur ^ 32'hA5A5_0000);
        end
    endfunction

    // wb/wn: 1-based data beat to stretch and number of wait states; exp_cyc counts from the accept edge.
    task automatic run_cmd(input logic wr, input logic [31:0] a, input logic [2:0] b, input logic [4:0] l,
                           input int eb, input logic [1:0] ecode, input int wb, input int wn, input int exp_cyc);
        aph_t        ap;
        logic        dph, prev_rdy, prev_err, idle_chk, got_done, acc, accepted;
        logic [31:0] dph_addr, prev_addr;
        logic [1:0]  prev_trans;
        int          dbeat, waits, errph, acks, n_ok, cyc;
        dph = 0; prev_rdy = 1; prev_err = 0; idle_chk = 0; got_done = 0; accepted = 0;
        dph_addr = 0; prev_addr = 0; prev_trans = HTRANS_IDLE;
        dbeat = 0; waits = 0; errph = 0; acks = 0;
        n_ok = (a[1:0] != 2'b00) ? 0 : (eb > 0) ? eb - 1 : nbeats(b, l);
        push_exp(wr, a, b, l, eb);
        @(negedge hclk);
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_burst = b; cmd_len = l;
        hready = 1; hresp = HRESP_OKAY;
        for (int i = 0; i < 20 && !accepted; i++) begin
            if (cmd_ready) accepted = 1;
            else @(negedge hclk);
        end
        check("cmd_accept", 32'(accepted), 1);
        @(posedge hclk); #1;
        cmd_valid = 0;
        for (cyc = 1; cyc < 100 && !got_done; cyc++) begin
            hready = 1; hresp = HRESP_OKAY;
            hrdata = dph_addr ^ 32'hA5A5_0000;
            wdata  = 32'hD000_0000 + 32'(dbeat);
            if (dph && eb == dbeat + 1) begin
                hresp = ecode;
                if (errph == 0) begin hready = 0; errph = 1; end
            end else if (dph && wb == dbeat + 1 && waits < wn) begin
                hready = 0;
                waits++;
            end
            #1;
            if (idle_chk) check("htrans_idle_after_err", 32'(htrans), 32'(HTRANS_IDLE));
            idle_chk = (hresp != HRESP_OKAY) && !hready;
            if (!prev_rdy && !prev_err) begin
                check("hold_haddr", haddr, prev_addr);
                check("hold_htrans", 32'(htrans), 32'(prev_trans));
            end
            check("hsize", 32'(hsize), 32'(HSIZE_WORD));
            acc = (htrans != HTRANS_IDLE) && hready;
            if (acc) begin
                if (exp_a.size() == 0) check("extra_aphase", 32'(htrans), 32'(HTRANS_IDLE));
                else begin
                    ap = exp_a.pop_front();
                    check("haddr", haddr, ap.addr);
                    check("htrans", 32'(htrans), 32'(ap.trans));
                    check("hburst", 32'(hburst), 32'(ap.burst));
                end
            end
            if (rdata_valid) begin
                if (exp_r.size() == 0) check("extra_rdata_valid", 32'(rdata_valid), 0);
                else check("rdata", rdata, exp_r.pop_front());
            end
            if (wdata_ack) begin
                check("hwdata", hwdata, 32'hD000_0000 + 32'(dbeat));
                acks++;
            end
            if (done) begin
                got_done = 1;
                check("err", 32'(err), 32'(exp_e.pop_front()));
                if (exp_cyc >= 0) check("done_cycle", 32'(cyc), 32'(exp_cyc));
                check("ready_while_busy", 32'(cmd_ready), 0);
            end
            if (hready) begin
                if (dph) dbeat++;
                dph      = acc;
                dph_addr = haddr;
            end
            prev_rdy   = hready;
            prev_err   = (hresp != HRESP_OKAY);
            prev_addr  = haddr;
            prev_trans = htrans;
            @(posedge hclk); #1;
        end
        if (!got_done) check("done_timeout", 32'(got_done), 1);
        check("ready_after_done", 32'(cmd_ready), 1);
        check("aphase_left", 32'(exp_a.size()), 0);
        check("rdata_left", 32'(exp_r.size()), 0);
        check("wdata_acks", 32'(acks), wr ? 32'(n_ok) : 0);
        exp_a.delete();
        exp_r.delete();
        exp_e.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        hreset = 1; cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h100; cmd_burst = HBURST_INCR4;
        cmd_len = 0; wdata = 0; hready = 1; hresp = HRESP_OKAY; hrdata = 0;
        repeat (3) @(posedge hclk);
        @(negedge hclk);
        check("rst_htrans", 32'(htrans), 32'(HTRANS_IDLE));
        check("rst_haddr", haddr, 0);
        check("rst_hwrite", 32'(hwrite), 0);
        check("rst_hburst", 32'(hburst), 0);
        check("rst_hsize", 32'(hsize), 32'(HSIZE_WORD));
        check("rst_cmd_ready", 32'(cmd_ready), 0);
        check("rst_wdata_req", 32'(wdata_req), 0);
        check("rst_wdata_ack", 32'(wdata_ack), 0);
        check("rst_rdata_valid", 32'(rdata_valid), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        cmd_valid = 0;
        @(negedge hclk);
        hreset = 0;

        run_cmd(1, 32'h100, HBURST_INCR4,  5'd0, 0, HRESP_OKAY,  0, 0, 5);
        run_cmd(0, 32'h03C, HBURST_WRAP8,  5'd0, 0, HRESP_OKAY,  0, 0, 9);
        run_cmd(1, 32'h3FC, HBURST_INCR,   5'd3, 0, HRESP_OKAY,  0, 0, 4);
        run_cmd(0, 32'h010, HBURST_SINGLE, 5'd0, 0, HRESP_OKAY,  1, 3, 5);
        run_cmd(1, 32'h080, HBURST_INCR8,  5'd0, 2, HRESP_ERROR, 0, 0, 4);
        run_cmd(1, 32'h102, HBURST_INCR4,  5'd0, 0, HRESP_OKAY,  0, 0, 1);
        run_cmd(0, 32'h008, HBURST_WRAP4,  5'd0, 0, HRESP_OKAY,  2, 2, 7);
        run_cmd(0, 32'h040, HBURST_INCR,   5'd0, 0, HRESP_OKAY,  0, 0, 2);
        run_cmd(0, 32'h200, HBURST_INCR4,  5'd0, 1, HRESP_RETRY, 0, 0, 3);
        run_cmd(1, 32'h0F4, HBURST_WRAP16, 5'd0, 0, HRESP_OKAY,  0, 0, 17);

        // Reset in the middle of an INCR8 write: burst dropped, no completion pulse.
        @(negedge hclk);
        check("mid_rst_ready_before", 32'(cmd_ready), 1);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h200; cmd_burst = HBURST_INCR8; cmd_len = 0;
        hready = 1; hresp = HRESP_OKAY;
        @(posedge hclk); #1;
        cmd_valid = 0;
        repeat (3) begin
            @(negedge hclk);
            check("mid_rst_busy_ready", 32'(cmd_ready), 0);
            check("mid_rst_no_done", 32'(done), 0);
        end
        @(negedge hclk);
        hreset = 1;
        #1;
        check("mid_rst_htrans", 32'(htrans), 32'(HTRANS_IDLE));
        check("mid_rst_done_in_rst", 32'(done), 0);
        @(negedge hclk);
        check("mid_rst_ready_in_rst", 32'(cmd_ready), 0);
        hreset = 0;
        #1;
        check("mid_rst_ready_after", 32'(cmd_ready), 1);
        check("mid_rst_done_after", 32'(done), 0);

        run_cmd(0, 32'h300, HBURST_INCR4, 5'd0, 0, HRESP_OKAY, 0, 0, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
